// File: rtl/jtdd_gfx_arb_pkg.sv
// Shared encodings for the video ROM arbiter: client ids, FSM states and
// the width of the object-starvation counter.
package jtdd_gfx_arb_pkg;

  typedef enum logic [1:0] {
    CLI_CHAR = 2'd0,
    CLI_SCR  = 2'd1,
    CLI_OBJ  = 2'd2
  } client_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_e;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/jtdd_gfx_slot.sv
// One-word tagged read buffer for a single ROM client. Addresses below
// TAG_LSB select bytes inside the buffered word and are not part of the tag.
module jtdd_gfx_slot #(
  parameter int AW      = 16,
  parameter int TAG_LSB = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic [AW-1:0]         addr,
  input  logic                  wr,
  input  logic [AW-TAG_LSB-1:0] wr_tag,
  input  logic [15:0]           din,
  output logic [15:0]           dout,
  output logic                  ok,
  output logic                  pending
);

  localparam int TW = AW - TAG_LSB;

  logic [TW-1:0] tag;
  logic          valid;
  logic          hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag   <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else if (wr) begin
      tag   <= wr_tag;
      valid <= 1'b1;
      dout  <= din;
    end
  end

  assign hit     = valid && (addr[AW-1:TAG_LSB] == tag);
  assign ok      = cs && hit;
  assign pending = cs && !hit;

  generate
    if (TAG_LSB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^addr[TAG_LSB-1:0];
    end
  endgenerate

endmodule

// File: rtl/jtdd_gfx_arb.sv
// Shares one SDRAM read port between the char, scroll and object ROM
// fetchers, with a one-word tagged buffer per client.
module jtdd_gfx_arb
  import jtdd_gfx_arb_pkg::*;
#(
  parameter int                    AW          = 22,
  parameter logic [AW-1:0]         CHAR_OFFSET = 22'h00000,
  parameter logic [AW-1:0]         SCR_OFFSET  = 22'h08000,
  parameter logic [AW-1:0]         OBJ_OFFSET  = 22'h18000,
  parameter logic [STARVE_W-1:0]   STARVE_MAX  = 4'd8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          char_cs,
  input  logic [15:0]   char_addr,
  output logic [7:0]    char_data,
  output logic          char_ok,
  input  logic          scr_cs,
  input  logic [16:0]   scr_addr,
  output logic [15:0]   scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [18:0]   obj_addr,
  output logic [15:0]   obj_data,
  output logic          obj_ok,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [15:0]   sdram_din
);

  state_e                state, state_nxt;
  client_e               gnt_sel, gnt_p1;
  logic [18:0]           gnt_word, lat_addr_p1;
  logic [AW-1:0]         gnt_off;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  char_pend, scr_pend, obj_pend, any_pend, force_obj;
  logic                  wr_char, wr_scr, wr_obj;
  logic [15:0]           char_buf;

  jtdd_gfx_slot #(.AW(16), .TAG_LSB(1)) u_char (
    .clk(clk), .rst_n(rst_n), .cs(char_cs), .addr(char_addr), .wr(wr_char),
    .wr_tag(lat_addr_p1[14:0]), .din(sdram_din), .dout(char_buf),
    .ok(char_ok), .pending(char_pend)
  );

  jtdd_gfx_slot #(.AW(17), .TAG_LSB(0)) u_scr (
    .clk(clk), .rst_n(rst_n), .cs(scr_cs), .addr(scr_addr), .wr(wr_scr),
    .wr_tag(lat_addr_p1[16:0]), .din(sdram_din), .dout(scr_data),
    .ok(scr_ok), .pending(scr_pend)
  );

  jtdd_gfx_slot #(.AW(19), .TAG_LSB(0)) u_obj (
    .clk(clk), .rst_n(rst_n), .cs(obj_cs), .addr(obj_addr), .wr(wr_obj),
    .wr_tag(lat_addr_p1), .din(sdram_din), .dout(obj_data),
    .ok(obj_ok), .pending(obj_pend)
  );

  assign char_data = char_addr[0] ? char_buf[15:8] : char_buf[7:0];

  // Objects jump the fixed priority once they have waited STARVE_MAX grants
  always_comb begin
    any_pend  = char_pend || scr_pend || obj_pend;
    force_obj = obj_pend && (starve_cnt == STARVE_MAX);
    gnt_sel   = CLI_OBJ;
    gnt_word  = obj_addr;
    gnt_off   = OBJ_OFFSET;
    if (!force_obj && char_pend) begin
      gnt_sel  = CLI_CHAR;
      gnt_word = 19'(char_addr[15:1]);
      gnt_off  = CHAR_OFFSET;
    end else if (!force_obj && scr_pend) begin
      gnt_sel  = CLI_SCR;
      gnt_word = 19'(scr_addr);
      gnt_off  = SCR_OFFSET;
    end
  end

  // Request stage: grant, latched tag and SDRAM address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_p1      <= CLI_CHAR;
      lat_addr_p1 <= '0;
      sdram_addr  <= '0;
      starve_cnt  <= '0;
    end else if (state == ST_IDLE) begin
      if (any_pend) begin
        gnt_p1      <= gnt_sel;
        lat_addr_p1 <= gnt_word;
        sdram_addr  <= gnt_off + AW'(gnt_word);
      end
      if (!obj_pend || gnt_sel == CLI_OBJ)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (any_pend)  state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (sdram_ack) state_nxt = ST_WAIT_DATA;
      ST_WAIT_DATA: if (data_rdy)  state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sdram_req = (state == ST_WAIT_ACK);
    wr_char   = (state == ST_WAIT_DATA) && data_rdy && (gnt_p1 == CLI_CHAR);
    wr_scr    = (state == ST_WAIT_DATA) && data_rdy && (gnt_p1 == CLI_SCR);
    wr_obj    = (state == ST_WAIT_DATA) && data_rdy && (gnt_p1 == CLI_OBJ);
  end

endmodule

// File: tb/tb_jtdd_gfx_arb.sv
// Bench for jtdd_gfx_arb: transaction-level model of the arbiter, an SDRAM
// responder, and directed scenarios with literal expectations.
module tb_jtdd_gfx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        char_cs, scr_cs, obj_cs;
  logic [15:0] char_addr;
  logic [16:0] scr_addr;
  logic [18:0] obj_addr;
  logic [7:0]  char_data;
  logic [15:0] scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;
  logic        sdram_req, sdram_ack, data_rdy;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_din;

  logic        rsp_en, man_ack, man_rdy;
  logic [15:0] man_din;
  logic        auto_ack = 1'b0, auto_rdy = 1'b0;
  logic [15:0] auto_din = 16'h0;

  assign sdram_ack = rsp_en ? auto_ack : man_ack;
  assign data_rdy  = rsp_en ? auto_rdy : man_rdy;
  assign sdram_din = rsp_en ? auto_din : man_din;

  always #5 clk = ~clk;

  jtdd_gfx_arb dut (
    .clk(clk), .rst_n(rst_n),
    .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .sdram_din(sdram_din)
  );

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    if (a == 22'h00092) return 16'hBEEF;
    return a[15:0] ^ 16'hC35A ^ {10'd0, a[21:16]};
  endfunction

  // SDRAM: ack in the first request cycle, data two cycles later
  logic        rsp_busy = 1'b0;
  int          rsp_cnt = 0;
  logic [21:0] rsp_a = '0;
  initial forever begin
    @(posedge clk);
    #1;
    auto_ack = 1'b0;
    auto_rdy = 1'b0;
    if (!rst_n) rsp_busy = 1'b0;
    else if (!rsp_busy && sdram_req) begin
      auto_ack = 1'b1; rsp_busy = 1'b1; rsp_cnt = 0; rsp_a = sdram_addr;
    end else if (rsp_busy) begin
      rsp_cnt++;
      if (rsp_cnt == 2) begin
        auto_rdy = 1'b1; auto_din = mem_word(rsp_a); rsp_busy = 1'b0;
      end
    end
  end

  // Transaction-level model: one outstanding read, per-client tagged word
  logic        m_busy = 1'b0, m_acked = 1'b0;
  int          m_cli = 0, m_starve = 0;
  logic [18:0] m_lat = '0;
  logic [21:0] m_exp = '0;
  logic        m_val [3];
  logic [18:0] m_tag [3];
  logic [15:0] m_buf [3];

  function automatic logic [18:0] cur_word(input int c);
    case (c)
      0:       return {4'd0, char_addr[15:1]};
      1:       return {2'd0, scr_addr};
      default: return obj_addr;
    endcase
  endfunction

  function automatic logic cur_cs(input int c);
    case (c)
      0:       return char_cs;
      1:       return scr_cs;
      default: return obj_cs;
    endcase
  endfunction

  function automatic logic [21:0] base_of(input int c);
    case (c)
      0:       return 22'h00000;
      1:       return 22'h08000;
      default: return 22'h18000;
    endcase
  endfunction

  function automatic logic m_hit(input int c);
    return m_val[c] && (m_tag[c] == cur_word(c));
  endfunction

  function automatic logic m_pend(input int c);
    return cur_cs(c) && !m_hit(c);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_acked = 1'b0; m_starve = 0;
      for (int i = 0; i < 3; i++) begin
        m_val[i] = 1'b0; m_tag[i] = '0; m_buf[i] = '0;
      end
    end else if (m_busy && !m_acked) begin
      if (sdram_ack) m_acked = 1'b1;
    end else if (m_busy) begin
      if (data_rdy) begin
        m_buf[m_cli] = sdram_din; m_tag[m_cli] = m_lat; m_val[m_cli] = 1'b1;
        m_busy = 1'b0;
      end
    end else begin
      logic p0, p1, p2;
      p0 = m_pend(0); p1 = m_pend(1); p2 = m_pend(2);
      if (!p2) m_starve = 0;
      if (p0 || p1 || p2) begin
        if (p2 && m_starve == 8) m_cli = 2;
        else if (p0)             m_cli = 0;
        else if (p1)             m_cli = 1;
        else                     m_cli = 2;
        if (m_cli == 2)  m_starve = 0;
        else if (p2 && m_starve < 8) m_starve++;
        m_lat   = cur_word(m_cli);
        m_exp   = base_of(m_cli) + 22'(m_lat);
        m_busy  = 1'b1;
        m_acked = 1'b0;
      end
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [21:0] gl [$];
  logic        req_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_quiet(input int bound, input string nm);
    int n = 0;
    while ((m_busy || m_pend(0) || m_pend(1) || m_pend(2)) && n < bound) begin
      drv();
      n++;
    end
    chk(nm, 32'(n < bound), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    rsp_en = 1'b1; man_ack = 1'b0; man_rdy = 1'b0; man_din = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic compare_loop();
    forever begin
      logic exp_req;
      smp();
      exp_req = m_busy && !m_acked;
      chk("sdram_req", 32'(sdram_req), 32'(exp_req));
      if (exp_req) chk("sdram_addr", 32'(sdram_addr), 32'(m_exp));
      chk("char_ok", 32'(char_ok), 32'(char_cs && m_hit(0)));
      chk("char_data", 32'(char_data),
          32'(char_addr[0] ? m_buf[0][15:8] : m_buf[0][7:0]));
      chk("scr_ok", 32'(scr_ok), 32'(scr_cs && m_hit(1)));
      chk("scr_data", 32'(scr_data), 32'(m_buf[1]));
      chk("obj_ok", 32'(obj_ok), 32'(obj_cs && m_hit(2)));
      chk("obj_data", 32'(obj_data), 32'(m_buf[2]));
      if (sdram_req && !req_prev) gl.push_back(sdram_addr);
      req_prev = sdram_req;
    end
  endtask

  task automatic run_tests();
    logic [15:0] t6_word;
    int first, second;
    logic moved;
    char_addr = '0; scr_addr = '0; obj_addr = '0;
    rst_n = 1'b1;
    #1 do_reset();

    // Minimum-latency char fetch, then the other byte of the same word
    drv(); char_cs = 1'b1; char_addr = 16'h0124;
    smp(); chk("t1_req_n", 32'(sdram_req), 32'd0);
    smp(); chk("t1_req_n1", 32'(sdram_req), 32'd1);
    chk("t1_addr", 32'(sdram_addr), 32'h00092);
    smp(); smp(); chk("t1_ok_n3", 32'(char_ok), 32'd0);
    smp(); chk("t1_ok_n4", 32'(char_ok), 32'd1);
    chk("t1_data_lo", 32'(char_data), 32'hEF);
    drv(); char_addr = 16'h0125;
    smp(); chk("t1_ok_hi", 32'(char_ok), 32'd1);
    chk("t1_data_hi", 32'(char_data), 32'hBE);
    for (int i = 0; i < 3; i++) begin
      drv(); smp(); chk("t1_no_req", 32'(sdram_req), 32'd0);
    end

    // All three clients at once
    do_reset();
    drv(); gl.delete();
    char_cs = 1'b1; scr_cs = 1'b1; obj_cs = 1'b1;
    char_addr = 16'h0124; scr_addr = 17'h00345; obj_addr = 19'h01234;
    wait_quiet(100, "t2_done");
    chk("t2_ngrants", 32'(gl.size()), 32'd3);
    while (gl.size() < 3) gl.push_back('1);
    chk("t2_g0", 32'(gl[0]), 32'h00092);
    chk("t2_g1", 32'(gl[1]), 32'h08345);
    chk("t2_g2", 32'(gl[2]), 32'h19234);
    smp(); chk("t2_obj_data", 32'(obj_data), 32'(mem_word(22'h19234)));

    // Char keeps missing; obj must break through every 9th grant
    do_reset();
    drv(); gl.delete();
    char_cs = 1'b1; scr_cs = 1'b1; obj_cs = 1'b1;
    char_addr = 16'h1000; scr_addr = 17'h00100; obj_addr = 19'h00700;
    first = 0; second = 0; moved = 1'b0;
    for (int k = 0; k < 400 && second == 0; k++) begin
      drv();
      char_addr = char_addr + 16'd2;
      scr_addr  = scr_addr + 17'd1;
      for (int i = 0; i < gl.size(); i++)
        if (gl[i] >= 22'h18000) begin
          if (first == 0) first = i + 1;
          else if (i + 1 > first && second == 0) second = i + 1;
        end
      if (first != 0 && !moved) begin
        obj_addr = 19'h00701;
        moved = 1'b1;
      end
    end
    chk("t3_first_obj", 32'(first), 32'd9);
    chk("t3_obj_gap", 32'(second - first), 32'd9);
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    wait_quiet(50, "t3_done");

    // Scroll address moves while its data is in flight
    do_reset();
    drv(); scr_cs = 1'b1; scr_addr = 17'h00010;
    smp();
    drv(); smp(); chk("t4_req1", 32'(sdram_req), 32'd1);
    chk("t4_addr1", 32'(sdram_addr), 32'h08010);
    drv(); scr_addr = 17'h00020;
    smp(); chk("t4_wait_data", 32'(sdram_req), 32'd0);
    smp(); smp(); chk("t4_ok_stale", 32'(scr_ok), 32'd0);
    smp(); chk("t4_req2", 32'(sdram_req), 32'd1);
    chk("t4_addr2", 32'(sdram_addr), 32'h08020);
    wait_quiet(50, "t4_done");
    smp(); chk("t4_ok_final", 32'(scr_ok), 32'd1);

    // Reset while waiting for ack
    do_reset();
    drv(); rsp_en = 1'b0; obj_cs = 1'b1; obj_addr = 19'h00055;
    smp();
    drv(); smp(); chk("t5_req", 32'(sdram_req), 32'd1);
    chk("t5_addr", 32'(sdram_addr), 32'h18055);
    drv(); rst_n = 1'b0;
    #1;
    chk("t5_req_rst", 32'(sdram_req), 32'd0);
    chk("t5_oks_rst", 32'({char_ok, scr_ok, obj_ok}), 32'd0);
    drv(); drv(); rst_n = 1'b1; rsp_en = 1'b1;
    smp(); chk("t5_req_idle", 32'(sdram_req), 32'd0);
    smp(); chk("t5_rereq", 32'(sdram_req), 32'd1);
    chk("t5_readdr", 32'(sdram_addr), 32'h18055);
    wait_quiet(50, "t5_done");
    smp(); chk("t5_ok", 32'(obj_ok), 32'd1);

    // Stray data_rdy in IDLE and in WAIT_ACK
    do_reset();
    drv(); char_cs = 1'b1; char_addr = 16'h0200;
    wait_quiet(50, "t6_fill");
    t6_word = mem_word(22'h00100);
    drv(); rsp_en = 1'b0; man_din = 16'h1111; man_rdy = 1'b1;
    smp(); chk("t6_idle_ok", 32'(char_ok), 32'd1);
    chk("t6_idle_data", 32'(char_data), 32'(t6_word[7:0]));
    drv(); man_rdy = 1'b0;
    smp(); chk("t6_idle_noreq", 32'(sdram_req), 32'd0);
    chk("t6_idle_data2", 32'(char_data), 32'(t6_word[7:0]));
    drv(); scr_cs = 1'b1; scr_addr = 17'h00007;
    smp();
    drv(); smp(); chk("t6_req", 32'(sdram_req), 32'd1);
    drv(); man_rdy = 1'b1; man_din = 16'h2222;
    smp(); chk("t6_ack_hold", 32'(sdram_req), 32'd1);
    drv(); man_rdy = 1'b0;
    smp(); chk("t6_ack_ok", 32'(scr_ok), 32'd0);
    chk("t6_ack_req", 32'(sdram_req), 32'd1);
    drv(); man_ack = 1'b1;
    smp();
    drv(); man_ack = 1'b0;
    smp(); chk("t6_req_drop", 32'(sdram_req), 32'd0);
    drv(); man_rdy = 1'b1; man_din = 16'h3333;
    drv(); man_rdy = 1'b0;
    smp(); chk("t6_scr_ok", 32'(scr_ok), 32'd1);
    chk("t6_scr_data", 32'(scr_data), 32'h3333);
    chk("t6_char_keep", 32'(char_data), 32'(t6_word[7:0]));
  endtask

  initial begin
    fork
      compare_loop();
      run_tests();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtdd_gfx_arb.md
Name: jtdd_gfx_arb

Overview:
- Arbitrates the three video ROM fetchers (char, scroll, object) onto one shared SDRAM read port with a req/ack/data-ready handshake.
- Holds a one-word tagged buffer per client. It asserts that client's ok while the buffered tag matches the client's current address.
- Sits between the video tile/sprite engines and the SDRAM controller, replacing per-layer SDRAM slots.

Parameters:
- AW, 22, SDRAM word-address width.
- CHAR_OFFSET, 22'h00000, SDRAM word base of char ROM.
- SCR_OFFSET, 22'h08000, SDRAM word base of scroll ROM.
- OBJ_OFFSET, 22'h18000, SDRAM word base of object ROM.
- STARVE_MAX, 4'd8, consecutive char/scr grants allowed while obj is pending before obj is forced.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- char_cs  in  1  char fetch enable
- char_addr  in  16  char byte address
- char_data  out  8  char ROM byte
- char_ok  out  1  char_data valid for char_addr
- scr_cs  in  1  scroll fetch enable
- scr_addr  in  17  scroll word address
- scr_data  out  16  scroll ROM word
- scr_ok  out  1  scr_data valid for scr_addr
- obj_cs  in  1  object fetch enable
- obj_addr  in  19  object word address
- obj_data  out  16  object ROM word
- obj_ok  out  1  obj_data valid for obj_addr
- sdram_req  out  1  read request
- sdram_addr  out  AW  read word address
- sdram_ack  in  1  request accepted
- data_rdy  in  1  sdram_din valid
- sdram_din  in  16  read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; sdram_req=0, sdram_addr=0.
  - All tags invalid, all data buffers 0, starve counter 0.
  - All *_ok=0, *_data=0.
  - sdram_req falls immediately, even mid-transaction.
- Per-client tag compare:
  - char compares addr[15:1]; scr and obj compare the full address.
  - hit = valid & tag==current addr.
  - *_ok = cs & hit, combinational from registers. It drops in the same cycle the address changes.
  - char_data = char_addr[0] ? buf[15:8] : buf[7:0], selected from the live addr[0].
- pending = cs & ~hit. When cs=0 the client is not pending and its tag/buffer are retained.
- State machine IDLE -> WAIT_ACK -> WAIT_DATA -> IDLE.
- IDLE: if any client is pending, grant one and register it.
  - Grant order: obj first if obj pending and starve==STARVE_MAX. Otherwise fixed priority char > scr > obj.
  - Latch client id and request address.
  - sdram_addr = offset + word address: char_addr[15:1] or the full scr/obj address, zero-extended. Sum is modulo 2^AW.
  - sdram_req=1 from the next cycle.
- WAIT_ACK: hold sdram_req and sdram_addr stable until sdram_ack=1 is sampled. sdram_req=0 the following cycle; go to WAIT_DATA.
- WAIT_DATA: on data_rdy=1:
  - Write sdram_din to the granted client's buffer.
  - tag <= latched address, valid <= 1.
  - Go to IDLE; a new grant is possible in that IDLE cycle.
- data_rdy outside WAIT_DATA is ignored.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on each char/scr grant made while obj is pending.
  - Clears on obj grant, or when obj is not pending in IDLE.
- Address change mid-flight: the returned data is still stored under the latched tag. The client sees ok=0 and is re-requested from IDLE. No abort is issued to SDRAM.
- cs dropped mid-flight: the transaction completes and the buffer is updated.
- Minimum latency:
  - pending at cycle N -> sdram_req high at N+1.
  - With ack at N+1 and data_rdy at N+3, ok=1 at N+4.
- Only one outstanding SDRAM request at any time.

Decomposition:
- Package jtdd_gfx_arb_pkg holds:
  - client id encoding (CHAR=0, SCR=1, OBJ=2)
  - state encoding (IDLE, WAIT_ACK, WAIT_DATA)
  - starve counter width constant
- Sub-module jtdd_gfx_slot, instantiated 3x, parameterised by address width and tag LSB. It holds the tag, valid, 16-bit buffer and hit/pending logic.
- The top holds the FSM, priority/starvation logic and offset adder.

Test Plan:
1. Reset then char_cs=1, char_addr=16'h0124; ack 1 cycle after req, data_rdy 2 cycles later with sdram_din=16'hBEEF -> sdram_addr=22'h00092, char_ok=1, char_data=8'hEF. Then char_addr=16'h0125 -> char_ok stays 1 with no new req, char_data=8'hBE.
2. char, scr and obj all pending at once -> grant order char, scr, obj. sdram_addr sequence 22'h00092, 22'h08000+scr_addr, 22'h18000+obj_addr.
3. char and scr toggling addresses continuously while obj is pending -> obj is granted no later than the 9th grant (STARVE_MAX=8). The counter then clears.
4. scr_addr changes from 17'h00010 to 17'h00020 while in WAIT_DATA -> scr_ok stays 0 after data_rdy, then a second req is issued with sdram_addr=22'h08020.
5. rst_n pulled low during WAIT_ACK -> sdram_req=0 immediately, all ok=0. After release, a pending client re-requests from IDLE.
6. data_rdy pulsed in IDLE and in WAIT_ACK -> no buffer, tag or ok change.
